dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data BRAM (port A) between the CPU load/store path and a DMA requester
//  (UART loader / block copy engine). Grants one requester per cycle. CPU has fixed priority.
//  A starvation counter forces a DMA grant after MAX_WAIT denied cycles.
//  Tracks the 1-cycle BRAM read latency and steers read data to the requester that issued the read.
// PARAMETERS
//  AW        14  word address width (BRAM depth 2^AW x 32b)
//  MAX_WAIT  8   consecutive denied DMA cycles before a forced DMA grant; legal range 1..255
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   asynchronous reset, active-high
//  cpu_req     in   1   CPU access request; must be held until cpu_gnt
//  cpu_we      in   4   byte write enables; 4'b0000 = read
//  cpu_addr    in   AW  word address
//  cpu_din     in   32  write data
//  cpu_gnt     out  1   access accepted this cycle (combinational)
//  cpu_rvalid  out  1   read data valid on cpu_dout (registered)
//  cpu_dout    out  32  read data
//  dma_req/dma_we/dma_addr/dma_din/dma_gnt/dma_rvalid/dma_dout   same as cpu_* for the DMA port
//  mem_en      out  1   BRAM port-A enable
//  mem_addra   out  AW  BRAM address
//  mem_dina    out  32  BRAM write data
//  mem_wea     out  4   BRAM byte write enables
//  mem_douta   in   32  BRAM read data, valid 1 cycle after a read enable
// BEHAVIOUR
//  - Reset: state=CPU_PRI, wait_cnt=0, rd_owner=0, cpu_rvalid=dma_rvalid=0.
//    While rst=1: cpu_gnt=dma_gnt=0, mem_en=0, mem_wea=0.
//  - States:
//    CPU_PRI: cpu_req wins; otherwise dma_req wins.
//    DMA_FORCE: dma_req wins; otherwise cpu_req wins.
//  - Transitions:
//    CPU_PRI -> DMA_FORCE when wait_cnt reaches MAX_WAIT-1 and DMA is denied this cycle.
//    DMA_FORCE -> CPU_PRI on the cycle dma_gnt=1, or when dma_req drops.
//  - wait_cnt increments when dma_req=1 and dma_gnt=0. It clears when dma_gnt=1 or dma_req=0.
//    It saturates at MAX_WAIT-1.
//  - Grant is combinational, same cycle as req. At most one gnt is high per cycle.
//    mem_en = cpu_gnt|dma_gnt. mem_addra, mem_dina and mem_wea come from the granted port.
//    mem_wea=0 when no grant.
//  - Read latency 1:
//    A granted read (we==0) registers rd_pending=1 and rd_owner=granted port.
//    Next cycle <owner>_rvalid=1 and <owner>_dout=mem_douta. The other port's rvalid stays 0.
//    Writes produce no rvalid.
//  - Back-to-back grants every cycle are legal, including alternating owners.
//    The read pipeline is 1 deep and never stalls.
//  - The *_dout of a non-owner port is don't-care. Verification checks dout only when rvalid=1.
//  - Simultaneous requests in CPU_PRI: CPU granted, DMA denied, wait_cnt++.
//  - A request dropped before grant is legal and is not an error (DMA abort).
//  - Reset mid-read: a pending rvalid is dropped (rvalid=0 after reset).
//    The BRAM write of the reset cycle is suppressed because mem_wea=0 while rst=1.
// STRUCTURE
//  - Shared package (riscv_core consts header): port ids ARB_CPU=1'b0, ARB_DMA=1'b1;
//    state encoding ARB_CPU_PRI=1'b0, ARB_DMA_FORCE=1'b1.
//  - Single module, no sub-module. The wait counter is $clog2(MAX_WAIT+1) bits.
// TESTING
//  1. Reset, then CPU read addr 0x0010 (BRAM holds 0xDEADBEEF) -> cpu_gnt=1 same cycle,
//     cpu_rvalid=1 next cycle with cpu_dout=0xDEADBEEF, dma_rvalid=0.
//  2. DMA write we=4'b0011 addr 0x0020 din 0x1234ABCD, CPU idle -> dma_gnt=1, mem_wea=4'b0011.
//     A later read of 0x0020 returns 0x????ABCD with the upper half unchanged.
//  3. cpu_req and dma_req held high continuously, MAX_WAIT=8 -> CPU granted cycles 0..7,
//     DMA granted cycle 8, CPU cycles 9..16, DMA cycle 17 (periodic 1-in-9).
//  4. Alternating reads: CPU addr A cycle n, DMA addr B cycle n+1 ->
//     cpu_rvalid at n+1 with mem[A], dma_rvalid at n+2 with mem[B]; never both high together.
//  5. DMA starved 5 cycles, then drops dma_req for 1 cycle, then reasserts ->
//     wait_cnt restarts at 0; the next forced grant comes 8 cycles after reassertion.
//  6. Assert rst while a CPU read is granted -> no rvalid on either port afterwards,
//     mem_wea=0 during reset, state=CPU_PRI after deassertion.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter.
//   arb_port_t  : identifies which requester owns a BRAM access (CPU or DMA)
//   arb_state_t : arbiter priority state (CPU priority or forced DMA grant)
package dmem_arbiter_pkg;

    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_DMA = 1'b1
    } arb_port_t;

    typedef enum logic {
        ARB_CPU_PRI   = 1'b0,
        ARB_DMA_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares BRAM port A between the CPU load/store path and a DMA requester.
//   The CPU has fixed priority, but a DMA requester denied MAX_WAIT consecutive
//   cycles gets one forced grant. Read data (1-cycle BRAM latency) is steered
//   back to the port that issued the read.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_req/we/addr/din      CPU request, byte enables (0 = read), address, data
//   cpu_gnt                  combinational accept for this cycle
//   cpu_rvalid/cpu_dout      read return, one cycle after a granted read
//   dma_*                    same set for the DMA requester
//   mem_en/addra/dina/wea    BRAM port-A controls driven by the granted port
//   mem_douta                BRAM read data
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = 14,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic [3:0]    cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_din,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_dout,
    input  logic          dma_req,
    input  logic [3:0]    dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [31:0]   dma_din,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [31:0]   dma_dout,
    output logic          mem_en,
    output logic [AW-1:0] mem_addra,
    output logic [31:0]   mem_dina,
    output logic [3:0]    mem_wea,
    input  logic [31:0]   mem_douta
);

    localparam int unsigned     WCW       = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MAX_WAIT - 1);

    arb_state_t     state;
    logic [WCW-1:0] wait_cnt;
    logic           rd_pending;
    arb_port_t      rd_owner;
    logic           dma_denied;

    // Grants are forced low during reset so no BRAM write slips through.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst) begin
            if (state == ARB_DMA_FORCE) begin
                dma_gnt = dma_req;
                cpu_gnt = cpu_req & ~dma_req;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req & ~cpu_req;
            end
        end
    end

    assign dma_denied = dma_req & ~dma_gnt;

    always_comb begin
        mem_en    = cpu_gnt | dma_gnt;
        mem_addra = dma_gnt ? dma_addr : cpu_addr;
        mem_dina  = dma_gnt ? dma_din  : cpu_din;
        mem_wea   = '0;
        if (dma_gnt)
            mem_wea = dma_we;
        else if (cpu_gnt)
            mem_wea = cpu_we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_CPU_PRI;
            wait_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= ARB_CPU;
        end else begin
            // Starvation counter: counts consecutive denied DMA cycles, saturating.
            if (dma_denied) begin
                if (wait_cnt != WAIT_LAST)
                    wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                ARB_CPU_PRI:
                    if (dma_denied && wait_cnt == WAIT_LAST)
                        state <= ARB_DMA_FORCE;
                ARB_DMA_FORCE:
                    if (dma_gnt || !dma_req)
                        state <= ARB_CPU_PRI;
                default:
                    state <= ARB_CPU_PRI;
            endcase

            // One-deep read tracker; a new grant every cycle simply replaces it.
            rd_pending <= (cpu_gnt && cpu_we == 4'b0000) ||
                          (dma_gnt && dma_we == 4'b0000);
            if (dma_gnt)
                rd_owner <= ARB_DMA;
            else if (cpu_gnt)
                rd_owner <= ARB_CPU;
        end
    end

    assign cpu_rvalid = rd_pending && (rd_owner == ARB_CPU);
    assign dma_rvalid = rd_pending && (rd_owner == ARB_DMA);
    assign cpu_dout   = mem_douta;
    assign dma_dout   = mem_douta;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: table-driven single-cycle vectors plus
// hand-written multi-cycle sequences (periodic forced DMA grant, starvation
// restart after a dropped request, reset during a pending read).
module tb_dmem_arbiter;

    localparam int unsigned AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, dma_req;
    logic [3:0]    cpu_we, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [31:0]   cpu_din, dma_din;
    logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic [31:0]   cpu_dout, dma_dout;
    logic          mem_en;
    logic [AW-1:0] mem_addra;
    logic [31:0]   mem_dina;
    logic [3:0]    mem_wea;
    logic [31:0]   mem_douta;
    logic          preload;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_dout(dma_dout),
        .mem_en(mem_en), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_wea(mem_wea), .mem_douta(mem_douta)
    );

    // Behavioural single-port BRAM with byte enables, read-first, 1-cycle latency.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (preload) begin
            mem[14'h010] <= 32'hDEADBEEF;
            mem[14'h020] <= 32'h55667788;
            mem[14'h030] <= 32'hA5A50001;
            mem[14'h040] <= 32'h0BADF00D;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) mem[mem_addra][8*b +: 8] <= mem_dina[8*b +: 8];
            mem_douta <= mem[mem_addra];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic cr, input logic [3:0] cwe, input logic [AW-1:0] ca,
                         input logic [31:0] cd, input logic dr, input logic [3:0] dwe,
                         input logic [AW-1:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_din = cd;
        dma_req = dr; dma_we = dwe; dma_addr = da; dma_din = dd;
    endtask

    typedef struct {
        logic          cr;  logic [3:0] cwe; logic [AW-1:0] ca; logic [31:0] cd;
        logic          dr;  logic [3:0] dwe; logic [AW-1:0] da; logic [31:0] dd;
        logic          e_cg; logic e_dg; logic [3:0] e_wea; logic [AW-1:0] e_addr; logic [31:0] e_din;
        logic          e_crv; logic e_drv; logic [31:0] e_dout;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // {cpu req,we,addr,din | dma req,we,addr,din | cpu_gnt,dma_gnt,wea,addr,din | cpu_rv,dma_rv,dout}
        vecs[0]  = '{1'b1, 4'h0, 14'h010, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b1, 1'b0, 4'h0, 14'h010, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b0, 1'b0, 4'h0, 14'h000, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b1, 4'h3, 14'h020, 32'h1234ABCD,
                     1'b0, 1'b1, 4'h3, 14'h020, 32'h1234ABCD, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 14'h020, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b1, 1'b0, 4'h0, 14'h020, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b1, 4'h0, 14'h030, 32'h0,
                     1'b0, 1'b1, 4'h0, 14'h030, 32'h0, 1'b1, 1'b0, 32'h5566ABCD};
        vecs[5]  = '{1'b1, 4'h0, 14'h040, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b1, 1'b0, 4'h0, 14'h040, 32'h0, 1'b0, 1'b1, 32'hA5A50001};
        vecs[6]  = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b1, 4'h0, 14'h010, 32'h0,
                     1'b0, 1'b1, 4'h0, 14'h010, 32'h0, 1'b1, 1'b0, 32'h0BADF00D};
        vecs[7]  = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b0, 1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 4'hF, 14'h040, 32'hCAFEF00D, 1'b1, 4'hF, 14'h050, 32'h11111111,
                     1'b1, 1'b0, 4'hF, 14'h040, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b0, 1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b1, 4'h0, 14'h040, 32'h0,
                     1'b0, 1'b1, 4'h0, 14'h040, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0,
                     1'b0, 1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D};

        // Reset with requests present: nothing may be granted or written.
        rst = 1'b1; preload = 1'b1;
        drive(1'b1, 4'hF, 14'h010, 32'h0, 1'b1, 4'hF, 14'h010, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst cpu_gnt", cpu_gnt, 0);
        chk("rst dma_gnt", dma_gnt, 0);
        chk("rst mem_en", mem_en, 0);
        chk("rst mem_wea", mem_wea, 0);
        chk("rst cpu_rvalid", cpu_rvalid, 0);
        chk("rst dma_rvalid", dma_rvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0; preload = 1'b0;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].cr, vecs[i].cwe, vecs[i].ca, vecs[i].cd,
                  vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dd);
            @(negedge clk);
            chk($sformatf("v%0d cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
            chk($sformatf("v%0d dma_gnt", i), dma_gnt, vecs[i].e_dg);
            chk($sformatf("v%0d mem_en", i), mem_en, vecs[i].e_cg | vecs[i].e_dg);
            chk($sformatf("v%0d mem_wea", i), mem_wea, vecs[i].e_wea);
            chk($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
            chk($sformatf("v%0d dma_rvalid", i), dma_rvalid, vecs[i].e_drv);
            if (vecs[i].e_cg | vecs[i].e_dg)
                chk($sformatf("v%0d mem_addra", i), mem_addra, vecs[i].e_addr);
            if (vecs[i].e_wea != 4'h0)
                chk($sformatf("v%0d mem_dina", i), mem_dina, vecs[i].e_din);
            if (vecs[i].e_crv)
                chk($sformatf("v%0d cpu_dout", i), cpu_dout, vecs[i].e_dout);
            if (vecs[i].e_drv)
                chk($sformatf("v%0d dma_dout", i), dma_dout, vecs[i].e_dout);
            @(posedge clk); #1;
        end

        // Both requesters held: DMA forced once every 9 cycles (cycles 8 and 17).
        begin
            logic pcg, pdg;
            pcg = 1'b0; pdg = 1'b0;
            drive(1'b1, 4'h0, 14'h010, 32'h0, 1'b1, 4'h0, 14'h030, 32'h0);
            for (int c = 0; c < 18; c++) begin
                @(negedge clk);
                chk($sformatf("pri c%0d cpu_gnt", c), cpu_gnt, (c != 8 && c != 17));
                chk($sformatf("pri c%0d dma_gnt", c), dma_gnt, (c == 8 || c == 17));
                if (c > 0) begin
                    chk($sformatf("pri c%0d cpu_rvalid", c), cpu_rvalid, pcg);
                    chk($sformatf("pri c%0d dma_rvalid", c), dma_rvalid, pdg);
                    if (pcg) chk($sformatf("pri c%0d cpu_dout", c), cpu_dout, 32'hDEADBEEF);
                    if (pdg) chk($sformatf("pri c%0d dma_dout", c), dma_dout, 32'hA5A50001);
                end
                pcg = (c != 8 && c != 17);
                pdg = (c == 8 || c == 17);
                @(posedge clk); #1;
            end
            drive(1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0);
            @(negedge clk);
            chk("pri tail dma_rvalid", dma_rvalid, 1);
            chk("pri tail dma_dout", dma_dout, 32'hA5A50001);
            chk("pri tail cpu_rvalid", cpu_rvalid, 0);
            @(posedge clk); #1;
        end

        // DMA starved 5 cycles, drops for one, reasserts: forced grant 8 cycles later.
        for (int c = 0; c < 15; c++) begin
            drive(1'b1, 4'h0, 14'h010, 32'h0, (c != 5), 4'h0, 14'h030, 32'h0);
            @(negedge clk);
            chk($sformatf("starve c%0d dma_gnt", c), dma_gnt, (c == 14));
            chk($sformatf("starve c%0d cpu_gnt", c), cpu_gnt, (c != 14));
            @(posedge clk); #1;
        end
        drive(1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0);
        @(posedge clk); #1;

        // Build up the starvation count, then reset while a CPU read is granted.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 4'h0, 14'h010, 32'h0, 1'b1, 4'h0, 14'h030, 32'h0);
            @(negedge clk);
            chk($sformatf("prerst c%0d cpu_gnt", c), cpu_gnt, 1);
            if (c == 5) begin
                #1;
                rst = 1'b1;
                cpu_we = 4'hF; cpu_din = 32'h00000000;
                #1;
                chk("inrst cpu_gnt", cpu_gnt, 0);
                chk("inrst dma_gnt", dma_gnt, 0);
                chk("inrst mem_en", mem_en, 0);
                chk("inrst mem_wea", mem_wea, 0);
                chk("inrst cpu_rvalid", cpu_rvalid, 0);
            end
            @(posedge clk); #1;
        end
        chk("inrst2 cpu_rvalid", cpu_rvalid, 0);
        chk("inrst2 dma_rvalid", dma_rvalid, 0);
        chk("inrst2 mem_wea", mem_wea, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b1, 4'h0, 14'h010, 32'h0, 1'b1, 4'h0, 14'h030, 32'h0);
        // Counter and state start fresh: CPU wins 8 cycles, then DMA forced.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("postrst c%0d cpu_gnt", c), cpu_gnt, (c != 8));
            chk($sformatf("postrst c%0d dma_gnt", c), dma_gnt, (c == 8));
            if (c == 0) begin
                chk("postrst cpu_rvalid", cpu_rvalid, 0);
                chk("postrst dma_rvalid", dma_rvalid, 0);
            end
            if (c == 1) begin
                chk("postrst rd cpu_rvalid", cpu_rvalid, 1);
                chk("postrst rd cpu_dout", cpu_dout, 32'hDEADBEEF);
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 4'h0, 14'h000, 32'h0, 1'b0, 4'h0, 14'h000, 32'h0);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
